// File: rtl/lfsr_replay_buf.sv
// Circular capture buffer for LFSR output words with oldest-to-newest replay
// over a valid/ready handshake; keeps the newest DEPTH samples.
module lfsr_replay_buf #(
  parameter int NBITS = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] q_in,
  input  logic             rec_en,
  input  logic             replay_req,
  input  logic             clr,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [AW:0]      count,
  output logic             busy,
  output logic             overflow
);

  localparam logic [1:0]  IDLE   = 2'd0;
  localparam logic [1:0]  RECORD = 2'd1;
  localparam logic [1:0]  REPLAY = 2'd2;
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  logic [1:0]       state;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      remaining;
  logic [NBITS-1:0] mem [DEPTH];

  logic             wr_en;
  logic [AW-1:0]    oldest;
  logic [AW-1:0]    rnext;

  // Write strobe and pointer arithmetic; a full buffer gives oldest == wptr.
  always_comb begin
    wr_en  = 1'b0;
    if (rec_en && ((state == IDLE) || (state == RECORD))) begin
      wr_en = 1'b1;
    end else begin
      wr_en = 1'b0;
    end
    oldest = wptr - count[AW-1:0];
    rnext  = rptr + AW'(1);
  end

  // Sample storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= q_in;
    end
  end

  // Control FSM, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wptr       <= {AW{1'b0}};
      rptr       <= {AW{1'b0}};
      remaining  <= {(AW+1){1'b0}};
      count      <= {(AW+1){1'b0}};
      dout       <= {NBITS{1'b0}};
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rec_en) begin
            state <= RECORD;
            busy  <= 1'b1;
          end else if (replay_req && (count != {(AW+1){1'b0}})) begin
            state      <= REPLAY;
            busy       <= 1'b1;
            rptr       <= oldest;
            dout       <= mem[oldest];
            dout_valid <= 1'b1;
            remaining  <= count;
          end else if (clr) begin
            count    <= {(AW+1){1'b0}};
            overflow <= 1'b0;
          end
        end
        RECORD: begin
          if (!rec_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        REPLAY: begin
          if (dout_valid && dout_ready) begin
            if (remaining == ONE) begin
              dout_valid <= 1'b0;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              rptr      <= rnext;
              dout      <= mem[rnext];
              remaining <= remaining - ONE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          dout_valid <= 1'b0;
        end
      endcase

      // A write into a full buffer drops the oldest entry instead of growing.
      if (wr_en) begin
        wptr <= wptr + AW'(1);
        if (count == FULL) begin
          overflow <= 1'b1;
        end else begin
          count <= count + ONE;
        end
      end
    end
  end

endmodule

// File: doc/lfsr_replay_buf.md
Name: lfsr_replay_buf

Overview:
Downstream consumer of the LFSR stage. Captures the LFSR output word `q` into a circular buffer while recording is enabled. On request, it replays the captured words oldest-to-newest over a valid/ready output handshake. The buffer retains the newest DEPTH samples so a pseudo-random sequence can be reproduced exactly for checking or re-injection.

Parameters:
- NBITS, 16, width of each captured LFSR word (matches the LFSR NBITS).
- DEPTH, 8, number of buffer entries; must be a power of 2, at least 2.
- AW, 3, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- q_in  input  NBITS  LFSR output word, sampled each cycle while recording.
- rec_en  input  1  record enable (level).
- replay_req  input  1  start-replay request (sampled in IDLE only).
- clr  input  1  synchronous clear of buffer bookkeeping (IDLE only).
- dout  output  NBITS  replayed word.
- dout_valid  output  1  dout holds a valid replay word.
- dout_ready  input  1  consumer accepts dout this cycle.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- busy  output  1  FSM not in IDLE.
- overflow  output  1  sticky flag: at least one entry was overwritten since the last reset or clr.

Behaviour:
- Reset (rst=0, async): state=IDLE, wptr=0, rptr=0, count=0, dout=0, dout_valid=0, busy=0, overflow=0. Memory contents are don't-care.
- States: IDLE, RECORD, REPLAY. `busy` is 1 in RECORD and REPLAY.
- IDLE transitions:
  - rec_en=1 goes to RECORD. The write happens the same cycle, so q_in is captured on the edge that leaves IDLE.
  - Otherwise, replay_req=1 with count>0 goes to REPLAY.
  - replay_req with count=0 is ignored.
  - rec_en and replay_req both high: record wins.
  - clr=1 (with rec_en=0) sets count=0 and overflow=0; pointers are unchanged.
  - clr is ignored outside IDLE.
- RECORD:
  - Every edge with rec_en=1 writes q_in to mem[wptr], and wptr increments modulo DEPTH.
  - If count<DEPTH, count increments.
  - If count=DEPTH, the oldest entry is overwritten, the oldest-index advances with wptr, and overflow is set to 1.
  - rec_en=0 returns to IDLE with no write that cycle.
  - replay_req is ignored.
- Oldest entry index = (wptr - count) mod DEPTH.
- REPLAY:
  - On entry edge: rptr=oldest, dout=mem[oldest], dout_valid=1. dout is therefore valid the cycle after replay_req is sampled.
  - Each edge with dout_valid&dout_ready advances to the next entry and loads dout with it.
  - After the count-th word is accepted: dout_valid=0 and state=IDLE.
  - With dout_ready=0, dout and dout_valid hold stable.
  - rec_en is ignored during replay.
  - Replay is non-destructive: count, wptr, overflow and memory are unchanged.
- Back-to-back replay: a replay_req in the first IDLE cycle after a replay replays the same data again.
- Reset mid-record or mid-replay: immediate return to reset values; dout_valid drops asynchronously.
- count never exceeds DEPTH; pointer wrap is modulo DEPTH with no gap.

Test Plan:
1. Basic record/replay: NBITS=16, DEPTH=8. Record 0x1111,0x2222,0x3333,0x4444,0x5555 over 5 cycles, then pulse replay_req with dout_ready=1.
   -> count=5; dout=0x1111..0x5555 on 5 consecutive cycles with dout_valid=1; then dout_valid=0, busy=0, overflow=0.
2. Overflow/wrap: record 0x0001..0x000A (10 words), then replay.
   -> count=8, overflow=1; dout sequence 0x0003..0x000A; count stays 8 afterwards.
3. Backpressure: as scenario 1, but hold dout_ready=0 for 3 cycles while dout=0x2222.
   -> dout=0x2222 and dout_valid=1 are held for all 3 cycles; sequence completes unchanged after ready returns.
4. Empty/priority:
   - replay_req with count=0 -> no dout_valid, state stays IDLE.
   - rec_en=1 and replay_req=1 together in IDLE -> RECORD entered, q_in written, no replay.
   - clr after scenario 2 -> count=0, overflow=0.
5. Async reset mid-replay: during scenario 1, drive rst=0 while dout=0x3333, between clock edges.
   -> dout_valid=0, count=0, busy=0 immediately. After rst=1, a replay_req is ignored (count=0).
6. Repeat replay: after scenario 1 completes, replay again.
   -> identical 0x1111..0x5555 sequence; count remains 5.
